// File: rtl/interrupt_controller.sv
// interrupt_controller: priority interrupt controller between the peripheral
// factor/mask registers and the CPU core microcode. Masked factor flags are
// reduced to six sources. The highest pending source is accepted at an
// instruction boundary while the I flag is set, and is then held through the
// core's acknowledge / service handshake.
// Optional feature macro: IRQ_HALT_WAKE_EN enables the HALT wake pulse and
// acceptance while halted without an instruction boundary.
module interrupt_controller #(
  parameter logic [12:0] VECTOR_BASE     = 13'h0100,
  parameter int          NUM_FACTOR_BITS = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_FACTOR_BITS-1:0] factor,
  input  logic [NUM_FACTOR_BITS-1:0] mask,
  input  logic                       interrupt_flag,
  input  logic                       instr_boundary,
  input  logic                       irq_ack,
  input  logic                       halt,
  output logic                       irq_req,
  output logic [12:0]                irq_vector,
  output logic [2:0]                 irq_source,
  output logic                       wake
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] vector_q, vector_d;
  logic [2:0]  source_q, source_d;
  logic        shadow_q, shadow_d;
  logic        iflag_q;
  logic [NUM_FACTOR_BITS-1:0] masked;
  logic [2:0]  winner;
  logic        iflagRise;
  logic        shadowEff;
  logic        trigger;

`ifdef IRQ_HALT_WAKE_EN
  logic wake_q, wake_d;
  logic armed_q, armed_d;
`else
  logic unused_halt;
  assign unused_halt = halt;
`endif

  // Priority encoder: later assignments override earlier ones, so the highest pending id wins
  always_comb begin
    masked = factor & mask;
    winner = 3'd0;
    if (|masked[3:0]) winner = 3'd1;
    if (|masked[5:4]) winner = 3'd2;
    if (masked[6])    winner = 3'd3;
    if (masked[7])    winner = 3'd4;
    if (masked[8])    winner = 3'd5;
    if (masked[9])    winner = 3'd6;
  end

  // A rising I flag counts as shadowed in the same cycle so a coincident boundary cannot accept
  assign iflagRise = interrupt_flag & ~iflag_q;
  assign shadowEff = shadow_q | iflagRise;

`ifdef IRQ_HALT_WAKE_EN
  assign trigger = instr_boundary | halt;
`else
  assign trigger = instr_boundary;
`endif

  // Next-state logic for the request handshake, the EI shadow and the wake pulse
  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    source_d = source_q;
    shadow_d = shadowEff;
`ifdef IRQ_HALT_WAKE_EN
    wake_d  = 1'b0;
    armed_d = armed_q;
    if (winner == 3'd0) begin
      armed_d = 1'b1;
    end else if (halt && armed_q) begin
      wake_d  = 1'b1;
      armed_d = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (trigger) begin
          shadow_d = 1'b0;
          if (interrupt_flag && (winner != 3'd0) && !shadowEff) begin
            state_d  = REQUEST;
            source_d = winner;
            vector_d = VECTOR_BASE + {9'd0, winner, 1'b0};
          end
        end
      end
      REQUEST: begin
        if (!interrupt_flag) begin
          state_d  = IDLE;
          source_d = 3'd0;
          vector_d = 13'h0000;
        end else if (irq_ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (!interrupt_flag) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      vector_q <= 13'h0000;
      source_q <= 3'd0;
      shadow_q <= 1'b0;
      iflag_q  <= 1'b0;
`ifdef IRQ_HALT_WAKE_EN
      wake_q   <= 1'b0;
      armed_q  <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      source_q <= source_d;
      shadow_q <= shadow_d;
      iflag_q  <= interrupt_flag;
`ifdef IRQ_HALT_WAKE_EN
      wake_q   <= wake_d;
      armed_q  <= armed_d;
`endif
    end
  end

  assign irq_req    = (state_q == REQUEST);
  assign irq_vector = vector_q;
  assign irq_source = source_q;
`ifdef IRQ_HALT_WAKE_EN
  assign wake = wake_q;
`else
  assign wake = 1'b0;
`endif

endmodule
